// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the 3-to-8 word-select decoder.
//  ADDR_W   : width of the word address {A2,A1,A0}
//  N_OUT    : number of word-select lines
//  onehot8  : reference one-hot decode of an address, gated by an enable
package decoder_pkg;

  localparam int ADDR_W = 3;
  localparam int N_OUT  = 8;

  function automatic logic [N_OUT-1:0] onehot8(input logic [ADDR_W-1:0] addr,
                                               input logic              en);
    logic [N_OUT-1:0] vec;
    vec = '0;
    for (int k = 0; k < N_OUT; k++) begin
      vec[k] = en & (addr == ADDR_W'(k));
    end
    return vec;
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with active-high enable.
//  A1, A0  : address bits (A1 is the MSB)
//  En      : enable; 0 forces all outputs low
//  Y0..Y3  : active-high select lines, one-hot or all-zero
module decoder_2to4 (
  input  logic A1,
  input  logic A0,
  input  logic En,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3
);

  assign Y0 = En & ~A1 & ~A0;
  assign Y1 = En & ~A1 &  A0;
  assign Y2 = En &  A1 & ~A0;
  assign Y3 = En &  A1 &  A0;

endmodule

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot word-select decoder for the memory row stage.
//  clk       : system clock, rising edge
//  rst       : synchronous reset, active-high
//  A2,A1,A0  : word address (A2 is the MSB)
//  Select    : enable; 0 forces every word select low
//  Z0..Z7    : word-select lines, active-high, one-hot or all-zero
//  OUT_REG   : 1 = outputs registered (1-cycle latency), 0 = combinational
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic Select,
  output logic Z0,
  output logic Z1,
  output logic Z2,
  output logic Z3,
  output logic Z4,
  output logic Z5,
  output logic Z6,
  output logic Z7
);

  logic [N_OUT-1:0] z_d;
  logic [N_OUT-1:0] z_out;
  logic             en_lo;
  logic             en_hi;

  // A2 picks which half of the word lines is live; the 2-to-4 stages
  // then resolve A1/A0 within that half.
  assign en_lo = Select & ~A2;
  assign en_hi = Select &  A2;

  decoder_2to4 u_dec_lo (
    .A1 (A1),
    .A0 (A0),
    .En (en_lo),
    .Y0 (z_d[0]),
    .Y1 (z_d[1]),
    .Y2 (z_d[2]),
    .Y3 (z_d[3])
  );

  decoder_2to4 u_dec_hi (
    .A1 (A1),
    .A0 (A0),
    .En (en_hi),
    .Y0 (z_d[4]),
    .Y1 (z_d[5]),
    .Y2 (z_d[6]),
    .Y3 (z_d[7])
  );

  generate
    if (OUT_REG) begin : g_out_reg
      logic [N_OUT-1:0] z_q;

      // Registering the whole vector at once means a simultaneous change
      // of Select and address never exposes an intermediate code.
      always_ff @(posedge clk) begin
        if (rst) begin
          z_q <= '0;
        end else begin
          z_q <= z_d;
        end
      end

      assign z_out = z_q;
    end else begin : g_out_comb
      // No state: reset simply masks the decode while it is high.
      assign z_out = rst ? '0 : z_d;
    end
  endgenerate

  assign Z0 = z_out[0];
  assign Z1 = z_out[1];
  assign Z2 = z_out[2];
  assign Z3 = z_out[3];
  assign Z4 = z_out[4];
  assign Z5 = z_out[5];
  assign Z6 = z_out[6];
  assign Z7 = z_out[7];

endmodule

// File: tb/tb_decoder_3to8.sv
module tb_decoder_3to8;

  logic clk;
  logic rst;
  logic A2, A1, A0;
  logic Select;

  logic r0, r1, r2, r3, r4, r5, r6, r7;
  logic c0, c1, c2, c3, c4, c5, c6, c7;

  logic [7:0] z_reg;
  logic [7:0] z_comb;

  int n_checks;
  int n_errors;

  logic [7:0] exp_q[$];

  assign z_reg  = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign z_comb = {c7, c6, c5, c4, c3, c2, c1, c0};

  decoder_3to8 #(.OUT_REG(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .A2     (A2),
    .A1     (A1),
    .A0     (A0),
    .Select (Select),
    .Z0 (r0), .Z1 (r1), .Z2 (r2), .Z3 (r3),
    .Z4 (r4), .Z5 (r5), .Z6 (r6), .Z7 (r7)
  );

  decoder_3to8 #(.OUT_REG(1'b0)) dut_comb (
    .clk    (clk),
    .rst    (rst),
    .A2     (A2),
    .A1     (A1),
    .A0     (A0),
    .Select (Select),
    .Z0 (c0), .Z1 (c1), .Z2 (c2), .Z3 (c3),
    .Z4 (c4), .Z5 (c5), .Z6 (c6), .Z7 (c7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08b expected %08b", tag, obs, exp);
    end
  endtask

  // Independent reference: shift a single bit into place.
  function automatic logic [7:0] model(input logic r, input logic sel, input logic [2:0] addr);
    logic [7:0] one;
    one = 8'd1;
    if (r || !sel) return 8'd0;
    return one << addr;
  endfunction

  // Drive one cycle of stimulus, check the combinational build in the same
  // timestep, then check the registered build one edge later.
  task automatic step(input string tag, input logic r, input logic sel, input logic [2:0] addr);
    logic [7:0] exp;
    logic [7:0] got_exp;
    rst    = r;
    Select = sel;
    {A2, A1, A0} = addr;
    exp_q.push_back(model(r, sel, addr));
    #1;
    check({tag, "_comb"}, z_comb, model(r, sel, addr));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      got_exp = exp_q.pop_front();
      check({tag, "_reg"}, z_reg, got_exp);
      check({tag, "_onehot"}, {7'd0, ($countones(z_reg) <= 1)}, 8'd1);
    end
    $display("txn %-12s rst=%0b sel=%0b addr=%03b z_reg=%08b z_comb=%08b",
             tag, r, sel, addr, z_reg, z_comb);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    Select = 1'b0;
    {A2, A1, A0} = 3'b000;

    // Reset state with an active request present.
    step("reset", 1'b1, 1'b1, 3'b101);

    // Disabled: every address must produce all-zero.
    for (int a = 0; a < 8; a++) step("sel0", 1'b0, 1'b0, 3'(a));

    // Enabled sweep: exactly Zk high one edge after addr = k.
    for (int a = 0; a < 8; a++) step("sweep", 1'b0, 1'b1, 3'(a));

    // Reset mid-operation, then recovery from the inputs at the release edge.
    step("rst_mid", 1'b1, 1'b1, 3'b011);
    step("rst_rel", 1'b0, 1'b1, 3'b011);

    // Select falling with address held at 111.
    step("z7_on", 1'b0, 1'b1, 3'b111);
    step("z7_off", 1'b0, 1'b0, 3'b111);

    // Select and address changing together.
    step("both_chg", 1'b0, 1'b1, 3'b010);
    step("both_chg2", 1'b0, 1'b0, 3'b101);
    step("both_chg3", 1'b0, 1'b1, 3'b110);

    // Random traffic, with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
